// File: rtl/neuron_core.sv
// Sequential single-neuron MAC engine with start/done handshake and step activation.
// Optional NEURON_SAT_EN: saturate each accumulate step instead of wrapping.
module neuron_core #(
    parameter int N    = 4,
    parameter int BW   = 8,
    parameter int ACCW = 16,
    parameter int BIAS = -50
) (
    input  logic                   CLK100MHZ,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic                   wr_sel,
    input  logic [2:0]             wr_addr,
    input  logic signed [BW-1:0]   wr_data,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   out,
    output logic signed [ACCW-1:0] acc_out
);

    typedef enum logic [1:0] {IDLE, MAC, FIN} state_t;

    localparam logic signed [ACCW-1:0] BIAS_V = ACCW'(BIAS);
    localparam logic [2:0]             LAST   = 3'(N - 1);

    state_t                 state, state_d;
    logic signed [BW-1:0]   w [N];
    logic signed [BW-1:0]   x [N];
    logic [2:0]             idx, idx_d;
    logic signed [ACCW-1:0] acc, acc_d, sum, acc_out_d;
    logic signed [2*BW-1:0] prod;
    logic                   busy_d, done_d, out_d;

    always_comb begin
        prod = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == 3'(i)) prod = w[i] * x[i];
        end
    end

`ifdef NEURON_SAT_EN
    logic signed [ACCW:0] wide;

    // One guard bit exposes overflow; clamp toward the sign of the true sum.
    always_comb begin
        wide = {acc[ACCW-1], acc} + (ACCW+1)'(prod);
        if (wide[ACCW] != wide[ACCW-1]) begin
            sum = wide[ACCW] ? {1'b1, {(ACCW-1){1'b0}}}
                             : {1'b0, {(ACCW-1){1'b1}}};
        end else begin
            sum = wide[ACCW-1:0];
        end
    end
`else
    assign sum = acc + ACCW'(prod);
`endif

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                w[i] <= '0;
                x[i] <= '0;
            end
        end else if (wr_en && state == IDLE) begin
            for (int i = 0; i < N; i++) begin
                if (wr_addr == 3'(i)) begin
                    if (wr_sel) w[i] <= wr_data;
                    else        x[i] <= wr_data;
                end
            end
        end
    end

    always_comb begin
        state_d   = state;
        acc_d     = acc;
        idx_d     = idx;
        busy_d    = busy;
        done_d    = 1'b0;
        out_d     = out;
        acc_out_d = acc_out;
        unique case (state)
            IDLE: begin
                if (start) begin
                    acc_d   = BIAS_V;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = sum;
                idx_d = idx + 3'd1;
                if (idx == LAST) state_d = FIN;
            end
            FIN: begin
                acc_out_d = acc;
                out_d     = (acc > 0);
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            idx     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            out     <= 1'b0;
            acc_out <= '0;
        end else begin
            state   <= state_d;
            acc     <= acc_d;
            idx     <= idx_d;
            busy    <= busy_d;
            done    <= done_d;
            out     <= out_d;
            acc_out <= acc_out_d;
        end
    end

endmodule

// File: tb/tb_neuron_core.sv
// Directed bench for neuron_core: scoreboard of expected results checked on done.
// Honours NEURON_SAT_EN when the same macro is defined for the build.
module tb_neuron_core;

    localparam int N    = 4;
    localparam int BW   = 8;
    localparam int ACCW = 16;
    localparam int BIAS = -50;

    typedef struct {
        longint acc;
        logic   o;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   wr_en;
    logic                   wr_sel;
    logic [2:0]             wr_addr;
    logic signed [BW-1:0]   wr_data;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   out;
    logic signed [ACCW-1:0] acc_out;

    int   checks = 0;
    int   errors = 0;
    int   sw [N];
    int   sx [N];
    exp_t sb [$];

    always #5 clk = ~clk;

    neuron_core #(.N(N), .BW(BW), .ACCW(ACCW), .BIAS(BIAS)) dut (
        .CLK100MHZ(clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .out      (out),
        .acc_out  (acc_out)
    );

    task automatic check(input string tag, input longint o, input longint e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    function automatic exp_t model();
        exp_t   r;
        longint a = BIAS;
        for (int i = 0; i < N; i++) begin
            a = a + longint'(sw[i]) * longint'(sx[i]);
`ifdef NEURON_SAT_EN
            if (a > 32767)  a = 32767;
            if (a < -32768) a = -32768;
`else
            a = a & 64'hFFFF;
            if (a >= 32768) a = a - 65536;
`endif
        end
        r.acc = a;
        r.o   = (a > 0);
        return r;
    endfunction

    task automatic wr(input bit sel, input int addr, input int data, input bit apply);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = 3'(addr);
        wr_data = BW'(data);
        if (apply) begin
            if (sel) sw[addr] = data;
            else     sx[addr] = data;
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load(input int wv [N], input int xv [N]);
        for (int i = 0; i < N; i++) wr(1'b1, i, wv[i], 1'b1);
        for (int i = 0; i < N; i++) wr(1'b0, i, xv[i], 1'b1);
    endtask

    // Optional write in the same cycle as start; shadow updated before the model runs.
    task automatic go(input bit we, input bit sel, input int addr, input int data);
        @(negedge clk);
        start = 1'b1;
        if (we) begin
            wr_en   = 1'b1;
            wr_sel  = sel;
            wr_addr = 3'(addr);
            wr_data = BW'(data);
            if (sel) sw[addr] = data;
            else     sx[addr] = data;
        end
        sb.push_back(model());
    endtask

    // guard=1 injects a second start and a w[0] write while the core is busy.
    task automatic run_check(input string tag, input bit guard);
        int   cyc  = 0;
        int   bcnt = 0;
        bit   seen = 0;
        exp_t e;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            wr_en = 1'b0;
            if (busy) bcnt++;
            if (done) seen = 1;
            if (guard && cyc == 2) start = 1'b1;
            if (guard && cyc == 3) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b1;
                wr_addr = 3'd0;
                wr_data = 8'sd99;
            end
        end
        check({tag, "_done_seen"}, longint'(seen), 1);
        if (seen) begin
            check({tag, "_latency"}, cyc - 1, N + 1);
            check({tag, "_busy_cycles"}, bcnt, N + 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({tag, "_acc_out"}, longint'(acc_out), e.acc);
                check({tag, "_out"}, longint'(out), longint'(e.o));
            end else begin
                check({tag, "_scoreboard_nonempty"}, 0, 1);
            end
            @(negedge clk);
            check({tag, "_done_one_cycle"}, longint'(done), 0);
            check({tag, "_busy_low"}, longint'(busy), 0);
        end
    endtask

    task automatic no_done(input string tag, input int ncyc);
        int cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check(tag, cnt, 0);
    endtask

    initial begin
        int wn [N] = '{10, 10, 10, 10};
        int xn [N] = '{1, 2, 3, 4};
        int x1 [N] = '{1, 1, 1, 1};
        int ws [N] = '{127, 127, 127, 127};
        for (int i = 0; i < N; i++) begin
            sw[i] = 0;
            sx[i] = 0;
        end
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_out", longint'(out), 0);
        check("rst_acc_out", longint'(acc_out), 0);
        rst_n = 1'b1;

        load(wn, xn);
        go(0, 0, 0, 0);
        run_check("nominal", 0);
        check("nominal_const", longint'(acc_out), 50);

        load(wn, x1);
        go(0, 0, 0, 0);
        run_check("negative", 0);
        check("negative_const", longint'(acc_out), -10);

        load(ws, ws);
        go(0, 0, 0, 0);
        run_check("saturation", 0);
`ifdef NEURON_SAT_EN
        check("saturation_const", longint'(acc_out), 32767);
`else
        check("saturation_const", longint'(acc_out), -1070);
`endif

        load(wn, xn);
        go(0, 0, 0, 0);
        run_check("guard", 1);
        no_done("guard_no_extra_done", 10);
        wr(1'b1, 5, 77, 1'b0);
        wr(1'b0, 5, 77, 1'b0);
        go(0, 0, 0, 0);
        run_check("guard_after", 0);
        check("guard_const", longint'(acc_out), 50);

        go(0, 0, 0, 0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", longint'(busy), 0);
        check("midrst_done", longint'(done), 0);
        check("midrst_acc_out", longint'(acc_out), 0);
        void'(sb.pop_back());
        for (int i = 0; i < N; i++) begin
            sw[i] = 0;
            sx[i] = 0;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        no_done("midrst_no_done", 8);
        go(0, 0, 0, 0);
        run_check("after_rst", 0);
        check("after_rst_const", longint'(acc_out), -50);

        load(wn, xn);
        go(1, 0, 3, 5);
        run_check("same_cycle", 0);
        check("same_cycle_const", longint'(acc_out), 60);

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_core.md
# neuron_core

Sequential single-neuron compute engine that answers the board-level start/done handshake: the top level pulses `start`, the core runs N multiply-accumulate steps over on-chip weight and input registers, then returns a registered step-activation bit and a one-cycle `done` pulse. Weights and inputs are loaded through a simple synchronous write port. The top level uses it as the programmable replacement for a fixed-weight perceptron.

## Interface
- `N`, 4: number of inputs and weights, legal range 2..8.
- `BW`, 8: signed width of each weight and each input.
- `ACCW`, 16: signed accumulator width; must satisfy ACCW ≥ 2*BW.
- `BIAS`, -50: signed ACCW-bit value the accumulator is preloaded with.

- `CLK100MHZ` input 1: single clock; all state is updated on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `wr_en` input 1: write strobe, sampled on the rising clock edge.
- `wr_sel` input 1: 1 selects the weight bank, 0 selects the input bank.
- `wr_addr` input 3: register index within the selected bank.
- `wr_data` input BW: signed write value.
- `start` input 1: compute request, single-cycle pulse.
- `busy` output 1: high while a computation is in progress.
- `done` output 1: one-cycle completion pulse.
- `out` output 1: step activation, 1 when the result is greater than 0.
- `acc_out` output ACCW: signed result of the last completed computation.

## Operation
- FSM states: IDLE, MAC, FIN. Reset state is IDLE.
- **IDLE:** when `start`=1, the core loads acc←sign-extended BIAS and idx←0, sets `busy`←1, and moves to MAC.
- **MAC:** each cycle, acc←acc + w[idx]*x[idx]. The product is 2*BW signed and is sign-extended to ACCW. idx increments each cycle. After the step with idx=N-1, the FSM moves to FIN.
- **FIN:** `acc_out`←acc; `out`←(acc > 0); `done`←1 for this cycle only; `busy`←0. Returns to IDLE.
- **Writes:**
  - A write is accepted only in IDLE.
  - Writes during MAC or FIN are dropped.
  - Writes with `wr_addr` ≥ N are dropped.
  - A write and `start` in the same IDLE cycle: the write commits at that edge, and the computation uses the new value.
- `start` while `busy`=1 is ignored; nothing is queued.
- `out` and `acc_out` hold their value until the next FIN.
- **Reset, including mid-computation:** all weights, inputs, acc, idx, `out`, `acc_out`, `done` and `busy` go to 0 immediately, and the FSM returns to IDLE. An interrupted computation never produces `done`.

## Timing
- `start` sampled high at edge k: `busy` is high from edge k to edge k+N+1.
- The MAC steps occur at edges k+1..k+N.
- `done`, `out` and `acc_out` update at edge k+N+1, so `done` is high in the cycle after that edge.
- Latency from `start` to `done` is N+1 cycles (5 for N=4).
- `busy` falls on the same edge that `done` rises. A new `start` in the `done` cycle is accepted.
- Back-to-back throughput: one result every N+2 cycles.
- Reset values: `busy`=0, `done`=0, `out`=0, `acc_out`=0.

## Configuration
- `NEURON_SAT_EN` defined: each accumulate saturates to the signed ACCW range, clamping to 2^(ACCW-1)-1 or -2^(ACCW-1). Clamping applies per step.
- `NEURON_SAT_EN` not defined: accumulation wraps modulo 2^ACCW (two's complement).

## Test plan
- **Nominal:** defaults, w=10,10,10,10 and x=1,2,3,4, then pulse `start` → `done` 5 cycles later, `acc_out`=50, `out`=1, `busy` high exactly 5 cycles.
- **Negative result:** same weights, x=1,1,1,1 → `acc_out`=-10, `out`=0.
- **Saturation:** w=127 and x=127 for all four inputs.
  - With `NEURON_SAT_EN`: `acc_out`=32767, `out`=1.
  - Without it: `acc_out`=-1070, `out`=0.
- **Guarding:**
  - Assert `start` again 2 cycles after the first start → ignored; one `done` only.
  - A write to w[0]=99 during MAC → dropped; the result is unchanged.
  - A write to `wr_addr`=5 → no effect.
- **Reset mid-MAC:** drop `rst_n` low on the 2nd MAC cycle → `busy`=0 at once and no `done`. After release, pulse `start` → `acc_out`=-50, `out`=0 (all registers cleared).
- **Same-cycle write and start:** write x[3]=5 together with `start` in IDLE, with the nominal weights → `acc_out`=60.
